command_framer: RTL

COMMAND_FRAMER -- requirements
Module: command_framer

---
 rtl/command_pkg.sv | 18 +
 rtl/reply_fifo.sv | 49 ++++
 rtl/command_framer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/command_pkg.sv
// Shared constants and types for the command framer: frame length,
// transmit state encoding and reply error-byte bit positions.
package command_pkg;

  localparam int unsigned FRAME_BYTES = 3;

  localparam int unsigned ERR_INVALID_CMD_BIT  = 0;
  localparam int unsigned ERR_INVALID_DATA_BIT = 1;
  localparam int unsigned ERR_OVERFLOW_BIT     = 7;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_B0   = 2'd1,
    TX_B1   = 2'd2,
    TX_B2   = 2'd3
  } tx_state_t;

endpackage

// File: rtl/reply_fifo.sv
// Reply word FIFO: wrap-around pointers plus a separate occupancy count.
// The caller gates push so that a full FIFO is only written alongside a pop.
module reply_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [23:0]              push_data,
  output logic [23:0]              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  localparam logic [AW:0] CAPACITY = (AW+1)'(DEPTH);

  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rptr];
  assign full  = (count == CAPACITY);
  assign empty = (count == '0);

endmodule

// File: rtl/command_framer.sv
// Host byte-stream framer: assembles 3-byte command words with an idle
// timeout, and serialises 24-bit reply words from a FIFO back to the host.
module command_framer #(
  parameter int unsigned REPLY_DEPTH    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        i_command_clk,
  input  logic        i_reset,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_byte,
  output logic        o_command,
  output logic [23:0] o_command_data,
  input  logic        i_reply,
  input  logic [23:0] i_reply_data,
  output logic        o_overflow,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_byte,
  input  logic        i_tx_ready,
  output logic        o_frame_drop
);

  import command_pkg::*;

  localparam int unsigned AW = $clog2(REPLY_DEPTH);
  localparam logic [AW:0] ONE_ENTRY = 1;
  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);
  localparam logic [1:0]  LAST_BYTE = 2'(FRAME_BYTES - 1);

  // ---------------- receive path ----------------
  logic [1:0]  rx_count;
  logic [15:0] rx_hold;
  logic [15:0] idle_count;
  logic        timeout_hit;

  assign timeout_hit = !i_rx_valid && (rx_count != '0) && (idle_count >= TIMEOUT);

  always_ff @(posedge i_command_clk) begin
    if (i_reset) begin
      rx_count       <= '0;
      rx_hold        <= '0;
      idle_count     <= '0;
      o_command      <= 1'b0;
      o_command_data <= '0;
      o_frame_drop   <= 1'b0;
    end else begin
      o_command    <= 1'b0;
      o_frame_drop <= 1'b0;
      if (i_rx_valid) begin
        idle_count <= '0;
        if (rx_count == LAST_BYTE) begin
          o_command_data <= {rx_hold, i_rx_byte};
          o_command      <= 1'b1;
          rx_count       <= '0;
        end else begin
          rx_hold  <= {rx_hold[7:0], i_rx_byte};
          rx_count <= rx_count + 2'd1;
        end
      end else begin
        if (idle_count != '1) idle_count <= idle_count + 16'd1;
        if (timeout_hit) begin
          rx_count     <= '0;
          o_frame_drop <= 1'b1;
        end
      end
    end
  end

  // ---------------- transmit path ----------------
  tx_state_t   state, state_next;
  logic [23:0] head;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  logic        pop, push_ok;
  logic        tx_valid;
  logic [7:0]  tx_byte;

  assign push_ok    = i_reply && (!fifo_full || pop);
  assign o_overflow = i_reply && fifo_full && !pop && !i_reset;

  reply_fifo #(.DEPTH(REPLY_DEPTH)) u_reply_fifo (
    .clk       (i_command_clk),
    .reset     (i_reset),
    .push      (push_ok),
    .pop       (pop),
    .push_data (i_reply_data),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge i_command_clk) begin
    if (i_reset) state <= TX_IDLE;
    else         state <= state_next;
  end

  // i_reply rather than push_ok decides B2->B0 to avoid a pop/push loop;
  // at one entry the FIFO cannot be full, so a reply is always accepted.
  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_byte    = '0;
    pop        = 1'b0;
    unique case (state)
      TX_IDLE: if (!fifo_empty) state_next = TX_B0;
      TX_B0: begin
        tx_valid = 1'b1;
        tx_byte  = head[23:16];
        if (i_tx_ready) state_next = TX_B1;
      end
      TX_B1: begin
        tx_valid = 1'b1;
        tx_byte  = head[15:8];
        if (i_tx_ready) state_next = TX_B2;
      end
      TX_B2: begin
        tx_valid = 1'b1;
        tx_byte  = head[7:0];
        if (i_tx_ready) begin
          pop        = 1'b1;
          state_next = ((fifo_count > ONE_ENTRY) || i_reply) ? TX_B0 : TX_IDLE;
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  assign o_tx_valid = tx_valid && !i_reset;
  assign o_tx_byte  = i_reset ? '0 : tx_byte;

endmodule
